scoreboard_point_arbiter: RTL and testbench
===========================================

# scoreboard_point_arbiter

Rally controller for the two-player scoreboard. It sits between the raw player buttons and the score-counter datapath. It debounces both buttons and arbitrates simultaneous presses round-robin. It issues exactly one single-cycle increment strobe per accepted point, enforces a post-point lockout, and evaluates the match rule (first to WIN_SCORE, win by WIN_MARGIN) using the scores fed back from the datapath.

## Interface
Parameters:
- SCORE_W, 8: score width, matching the datapath counters.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles before a button level is accepted; must be ≥1.
- LOCKOUT_CYCLES, 32: cycles after each point during which new presses are discarded; must be ≥1.
- WIN_SCORE, 11: minimum score needed to win.
- WIN_MARGIN, 2: required lead over the opponent.

Ports:
- clk_i, in, 1: the single clock.
- rst_ni, in, 1: asynchronous, active-low reset.
- p1_button_i, in, 1: raw player-1 button (asynchronous).
- p2_button_i, in, 1: raw player-2 button (asynchronous).
- new_game_i, in, 1: synchronous, clean new-game request. Its rising edge is the event.
- p1_score_i, in, SCORE_W: player-1 score from the datapath.
- p2_score_i, in, SCORE_W: player-2 score from the datapath.
- p1_inc_o, out, 1: one-cycle increment strobe for player 1.
- p2_inc_o, out, 1: one-cycle increment strobe for player 2.
- clear_o, out, 1: one-cycle score-clear strobe.
- game_over_o, out, 1: high while in GAME_OVER.
- winner_o, out, 2: 00 none, 01 P1, 10 P2.
- state_o, out, 3: current FSM state, for debug and display.

## Operation
- **Button conditioning:** each button passes through a 2-flop synchronizer, then a debounce counter. The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. A 0→1 transition of the debounced level produces a one-cycle press event.
- **Pending flags:** one per player.
  - Set by a press event in IDLE, GRANT, SETTLE or CHECK.
  - Press events in LOCKOUT or GAME_OVER are discarded.
  - The flag is cleared when that player is granted.
- **Priority bit:** selects the preferred player on a tie. Reset value is P1. After each grant it points to the other player.
- **FSM states:**
  - IDLE (0):
    - If no flag is pending, stay in IDLE.
    - If only one flag is pending, grant that player.
    - If both are pending, grant the priority player; the other flag stays set.
    - Granting a player whose score equals all-ones (2^SCORE_W−1) drops that flag, issues no strobe and stays in IDLE.
    - Otherwise go to GRANT.
  - GRANT (1): assert the granted player's inc_o for exactly one cycle, then go to SETTLE.
  - SETTLE (2): one cycle, giving the datapath time to register the increment. Then go to CHECK.
  - CHECK (3):
    - P1 wins if p1 ≥ WIN_SCORE and p1 − p2 ≥ WIN_MARGIN; P2 wins symmetrically. Compare unsigned, with SCORE_W+1-bit subtraction so there is no wrap.
    - On a win, latch winner_o and go to GAME_OVER; otherwise go to LOCKOUT.
  - LOCKOUT (4): count LOCKOUT_CYCLES cycles, then go to IDLE. Pending flags are cleared on entry.
  - GAME_OVER (5): hold here; winner_o and game_over_o are stable.
- **new_game_i rising edge:** takes precedence in every state. In the following cycle:
  - clear_o is asserted for one cycle;
  - the state goes to IDLE;
  - pending flags, the lockout counter and winner_o are cleared;
  - the priority bit is reset to P1.
  
  A press event arriving in the same cycle as the new_game edge is discarded.
- **Strobe exclusivity:** p1_inc_o and p2_inc_o are never high together, and never high in the same cycle as clear_o.

## Timing
- **Reset values:** every output is 0 and the state is IDLE. Pending flags and debounced levels are 0; the priority bit is P1.
- **Press latency:** raw edge, then 2 synchronizer cycles, then DEBOUNCE_CYCLES, giving the press event. The pending flag is set at the next edge. IDLE→GRANT happens at the edge after that, and inc_o is high for the following cycle. All outputs are registered (Moore).
- **Point cycle:** GRANT, SETTLE and CHECK take 3 cycles. A non-winning point then spends LOCKOUT_CYCLES in LOCKOUT before returning to IDLE.
- **Datapath contract:** scores must reflect an inc strobe by the start of the CHECK cycle, i.e. the counter registers on the edge ending GRANT.
- **Simultaneous presses:** both players are served back-to-back only if the second flag survives. It does not survive, because the LOCKOUT entry clears it. Simultaneous presses therefore award exactly one point, to the priority player.
- **Reset mid-operation:** asynchronous return to the reset values; an inc strobe in flight is cut off immediately.

## Structure
- **Shared package scoreboard_pkg:**
  - state encodings IDLE…GAME_OVER as 3-bit constants;
  - winner encodings WIN_NONE/WIN_P1/WIN_P2;
  - default DEBOUNCE/LOCKOUT/WIN constants.
- **Sub-module button_debouncer:** synchronizer, debounce counter and rising-edge pulse; parameter DEBOUNCE_CYCLES. Instantiated twice.
- The FSM, pending/priority logic and win compare live in scoreboard_point_arbiter itself.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8, WIN_SCORE=11, WIN_MARGIN=2, with a bench score model that increments on the strobes.
- **Single press:** assert p1_button_i for 20 cycles → exactly one p1_inc_o pulse, at cycle 8 after the raw edge; scores become 1–0; state passes through LOCKOUT for 8 cycles, then IDLE.
- **Bounce and lockout:** toggle p2_button_i every 2 cycles for 10 cycles, then hold high → at most one p2_inc_o. A second clean press during LOCKOUT → no strobe.
- **Simultaneous presses:** p1 and p2 press in the same cycle twice in a row, each after lockout → first p1_inc_o, then p2_inc_o; exactly one point each time.
- **Deuce:**
  - drive the score to 10–10, then P1 scores → 11–10, no win, LOCKOUT;
  - P1 scores again → 12–10, game_over_o=1, winner_o=01;
  - further presses → no strobes.
- **New game:** from GAME_OVER, pulse new_game_i → clear_o is high for one cycle; winner_o=00; state is IDLE; the next press gives p1_inc_o.
- **Async reset and saturation:**
  - assert rst_ni low during GRANT → p1_inc_o drops immediately and all outputs are 0;
  - with p1_score_i=255, press P1 → no strobe, state stays IDLE.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared encodings and default tuning constants for the scoreboard rally controller.
package scoreboard_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        SETTLE    = 3'd2,
        CHECK     = 3'd3,
        LOCKOUT   = 3'd4,
        GAME_OVER = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

    localparam int unsigned DEF_SCORE_W         = 8;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_LOCKOUT_CYCLES  = 32;
    localparam int unsigned DEF_WIN_SCORE       = 11;
    localparam int unsigned DEF_WIN_MARGIN      = 2;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stable-level debounce counter and registered rising-edge press pulse.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            // Any cycle where the input agrees with the accepted level restarts the run.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                press_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/scoreboard_point_arbiter.sv
// Rally controller: debounced button arbitration, one increment strobe per point,
// post-point lockout and match-rule evaluation against the datapath scores.
module scoreboard_point_arbiter
    import scoreboard_pkg::*;
#(
    parameter int unsigned SCORE_W         = DEF_SCORE_W,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
    parameter int unsigned WIN_SCORE       = DEF_WIN_SCORE,
    parameter int unsigned WIN_MARGIN      = DEF_WIN_MARGIN
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               p1_button_i,
    input  logic               p2_button_i,
    input  logic               new_game_i,
    input  logic [SCORE_W-1:0] p1_score_i,
    input  logic [SCORE_W-1:0] p2_score_i,
    output logic               p1_inc_o,
    output logic               p2_inc_o,
    output logic               clear_o,
    output logic               game_over_o,
    output logic [1:0]         winner_o,
    output logic [2:0]         state_o
);

    localparam int unsigned SW1    = SCORE_W + 1;
    localparam int unsigned LOCK_W = (LOCKOUT_CYCLES < 2) ? 1 : $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST    = LOCK_W'(LOCKOUT_CYCLES - 1);
    localparam logic [SCORE_W:0]  WIN_SCORE_X  = SW1'(WIN_SCORE);
    localparam logic [SCORE_W:0]  WIN_MARGIN_X = SW1'(WIN_MARGIN);

    // Widened subtraction keeps a trailing player's difference negative instead of wrapping.
    function automatic logic wins(input logic [SCORE_W-1:0] me, input logic [SCORE_W-1:0] other);
        logic [SCORE_W:0] diff;
        diff = {1'b0, me} - {1'b0, other};
        return ({1'b0, me} >= WIN_SCORE_X) && !diff[SCORE_W] && (diff >= WIN_MARGIN_X);
    endfunction

    logic p1_press, p2_press;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_p1 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (p1_button_i),
        .press_o (p1_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_p2 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (p2_button_i),
        .press_o (p2_press)
    );

    state_e            state_q;
    winner_e           winner_q;
    logic [LOCK_W-1:0] lock_cnt_q;
    logic              pend1_q, pend2_q;
    logic              prio_q;
    logic              ng_prev_q;
    logic              p1_inc_q, p2_inc_q, clear_q, game_over_q;

    logic ng_rise, accept_press, grant_p2, grant_sat;

    assign ng_rise      = new_game_i & ~ng_prev_q;
    assign accept_press = (state_q == IDLE) || (state_q == GRANT) ||
                          (state_q == SETTLE) || (state_q == CHECK);
    // prio_q = 1 prefers player 2 when both flags are pending.
    assign grant_p2     = pend2_q & (~pend1_q | prio_q);
    assign grant_sat    = grant_p2 ? (&p2_score_i) : (&p1_score_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            winner_q    <= WIN_NONE;
            lock_cnt_q  <= '0;
            pend1_q     <= 1'b0;
            pend2_q     <= 1'b0;
            prio_q      <= 1'b0;
            ng_prev_q   <= 1'b0;
            p1_inc_q    <= 1'b0;
            p2_inc_q    <= 1'b0;
            clear_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            ng_prev_q <= new_game_i;
            p1_inc_q  <= 1'b0;
            p2_inc_q  <= 1'b0;
            clear_q   <= 1'b0;
            if (ng_rise) begin
                clear_q     <= 1'b1;
                state_q     <= IDLE;
                winner_q    <= WIN_NONE;
                game_over_q <= 1'b0;
                lock_cnt_q  <= '0;
                pend1_q     <= 1'b0;
                pend2_q     <= 1'b0;
                prio_q      <= 1'b0;
            end else begin
                if (accept_press && p1_press) pend1_q <= 1'b1;
                if (accept_press && p2_press) pend2_q <= 1'b1;
                case (state_q)
                    IDLE: begin
                        if (pend1_q || pend2_q) begin
                            if (grant_p2) pend2_q <= 1'b0;
                            else          pend1_q <= 1'b0;
                            prio_q <= ~grant_p2;
                            // A saturated counter cannot take another point: drop the request silently.
                            if (!grant_sat) begin
                                p1_inc_q <= ~grant_p2;
                                p2_inc_q <= grant_p2;
                                state_q  <= GRANT;
                            end
                        end
                    end
                    GRANT:  state_q <= SETTLE;
                    SETTLE: state_q <= CHECK;
                    CHECK: begin
                        if (wins(p1_score_i, p2_score_i)) begin
                            winner_q    <= WIN_P1;
                            game_over_q <= 1'b1;
                            state_q     <= GAME_OVER;
                        end else if (wins(p2_score_i, p1_score_i)) begin
                            winner_q    <= WIN_P2;
                            game_over_q <= 1'b1;
                            state_q     <= GAME_OVER;
                        end else begin
                            lock_cnt_q <= '0;
                            pend1_q    <= 1'b0;
                            pend2_q    <= 1'b0;
                            state_q    <= LOCKOUT;
                        end
                    end
                    LOCKOUT: begin
                        if (lock_cnt_q == LOCK_LAST) state_q <= IDLE;
                        else lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
                    end
                    GAME_OVER: state_q <= GAME_OVER;
                    default:   state_q <= IDLE;
                endcase
            end
        end
    end

    assign p1_inc_o    = p1_inc_q;
    assign p2_inc_o    = p2_inc_q;
    assign clear_o     = clear_q;
    assign game_over_o = game_over_q;
    assign winner_o    = winner_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_scoreboard_point_arbiter.sv
// Scoreboard-driven bench for scoreboard_point_arbiter with a strobe-driven score model.
module tb_scoreboard_point_arbiter;

    typedef struct {
        logic [1:0]  who;
        int unsigned cyc;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       p1_btn, p2_btn, new_game;
    logic [7:0] p1_score, p2_score;
    logic       p1_inc_o, p2_inc_o, clear_o, game_over_o;
    logic [1:0] winner_o;
    logic [2:0] state_o;

    logic       load_en;
    logic [7:0] load_p1, load_p2;

    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    exp_t        exp_q[$];

    scoreboard_point_arbiter #(
        .SCORE_W         (8),
        .DEBOUNCE_CYCLES (4),
        .LOCKOUT_CYCLES  (8),
        .WIN_SCORE       (11),
        .WIN_MARGIN      (2)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .p1_button_i (p1_btn),
        .p2_button_i (p2_btn),
        .new_game_i  (new_game),
        .p1_score_i  (p1_score),
        .p2_score_i  (p2_score),
        .p1_inc_o    (p1_inc_o),
        .p2_inc_o    (p2_inc_o),
        .clear_o     (clear_o),
        .game_over_o (game_over_o),
        .winner_o    (winner_o),
        .state_o     (state_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Score counters that register the strobe on the edge ending GRANT.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p1_score <= 8'd0;
            p2_score <= 8'd0;
        end else if (load_en) begin
            p1_score <= load_p1;
            p2_score <= load_p2;
        end else if (clear_o) begin
            p1_score <= 8'd0;
            p2_score <= 8'd0;
        end else begin
            if (p1_inc_o) p1_score <= p1_score + 8'd1;
            if (p2_inc_o) p2_score <= p2_score + 8'd1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic push_exp(input logic [1:0] who, input int unsigned at);
        exp_t e;
        e.who = who;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic load_scores(input logic [7:0] a, input logic [7:0] b);
        load_p1 = a;
        load_p2 = b;
        load_en = 1'b1;
        tick(1);
        load_en = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (p1_inc_o || p2_inc_o) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_strobe", {30'd0, p2_inc_o, p1_inc_o}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("strobe_player", {30'd0, p2_inc_o, p1_inc_o}, {30'd0, e.who});
                check_val("strobe_cycle", cyc, e.cyc);
                check_val("strobe_vs_clear", clear_o, 0);
            end
        end
    end

    initial begin
        int unsigned c0;
        int          cnt;
        logic        found;

        rst_ni = 1'b0; p1_btn = 1'b0; p2_btn = 1'b0; new_game = 1'b0;
        load_en = 1'b0; load_p1 = 8'd0; load_p2 = 8'd0;
        tick(3);
        check_val("rst_p1_inc", p1_inc_o, 0);
        check_val("rst_p2_inc", p2_inc_o, 0);
        check_val("rst_clear", clear_o, 0);
        check_val("rst_game_over", game_over_o, 0);
        check_val("rst_winner", winner_o, 0);
        check_val("rst_state", state_o, 0);
        rst_ni = 1'b1;
        tick(2);

        // Single press
        c0 = cyc; p1_btn = 1'b1; push_exp(2'b01, c0 + 8);
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (state_o == 3'd4) cnt++;
            if (i == 19) check_val("s1_idle_after_lockout", state_o, 0);
        end
        check_val("s1_lockout_len", cnt, 8);
        check_val("s1_p1_score", p1_score, 1);
        check_val("s1_p2_score", p2_score, 0);
        p1_btn = 1'b0;
        tick(10);
        check_val("s1_queue_empty", exp_q.size(), 0);

        // Bounce, then a clean press during lockout
        c0 = cyc; push_exp(2'b10, c0 + 16);
        for (int t = 0; t <= 20; t++) begin
            if (t < 8) p2_btn = ((t % 4) < 2);
            else       p2_btn = 1'b1;
            if (t == 19) begin
                check_val("s2_in_lockout", state_o, 4);
                p1_btn = 1'b1;
            end
            tick(1);
        end
        tick(4);
        p1_btn = 1'b0; p2_btn = 1'b0;
        tick(20);
        check_val("s2_p1_score", p1_score, 1);
        check_val("s2_p2_score", p2_score, 1);
        check_val("s2_queue_empty", exp_q.size(), 0);

        // Simultaneous presses, twice
        for (int k = 0; k < 2; k++) begin
            c0 = cyc; p1_btn = 1'b1; p2_btn = 1'b1;
            push_exp((k == 0) ? 2'b01 : 2'b10, c0 + 8);
            tick(10);
            p1_btn = 1'b0; p2_btn = 1'b0;
            tick(20);
        end
        check_val("s3_p1_score", p1_score, 2);
        check_val("s3_p2_score", p2_score, 2);
        check_val("s3_queue_empty", exp_q.size(), 0);

        // Deuce
        load_scores(8'd10, 8'd10);
        for (int k = 0; k < 2; k++) begin
            c0 = cyc; p1_btn = 1'b1; push_exp(2'b01, c0 + 8);
            for (int i = 1; i <= 12; i++) begin
                tick(1);
                if (i == 11) begin
                    check_val("s4_state", state_o, (k == 0) ? 4 : 5);
                    check_val("s4_game_over", game_over_o, (k == 0) ? 0 : 1);
                    check_val("s4_winner", winner_o, (k == 0) ? 0 : 1);
                end
            end
            p1_btn = 1'b0;
            tick(20);
        end
        check_val("s4_p1_score", p1_score, 12);
        check_val("s4_p2_score", p2_score, 10);
        p1_btn = 1'b1; p2_btn = 1'b1;
        tick(12);
        p1_btn = 1'b0; p2_btn = 1'b0;
        tick(10);
        check_val("s4_still_over", state_o, 5);
        check_val("s4_winner_hold", winner_o, 1);
        check_val("s4_no_strobe_after", p1_score + p2_score, 22);

        // New game
        new_game = 1'b1;
        tick(1);
        check_val("s5_clear_high", clear_o, 1);
        check_val("s5_state_idle", state_o, 0);
        check_val("s5_winner_none", winner_o, 0);
        check_val("s5_game_over_low", game_over_o, 0);
        tick(1);
        new_game = 1'b0;
        check_val("s5_clear_one_cycle", clear_o, 0);
        check_val("s5_scores_cleared", p1_score + p2_score, 0);
        c0 = cyc; p1_btn = 1'b1; push_exp(2'b01, c0 + 8);
        tick(12);
        p1_btn = 1'b0;
        tick(20);
        check_val("s5_p1_score", p1_score, 1);
        check_val("s5_queue_empty", exp_q.size(), 0);

        // Async reset during GRANT
        p1_btn = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (state_o == 3'd1) found = 1'b1;
        end
        check_val("s6_reached_grant", found, 1);
        if (found) check_val("s6_inc_in_grant", p1_inc_o, 1);
        rst_ni = 1'b0; p1_btn = 1'b0;
        #1;
        check_val("s6_inc_cut", p1_inc_o, 0);
        check_val("s6_p2_inc", p2_inc_o, 0);
        check_val("s6_clear", clear_o, 0);
        check_val("s6_game_over", game_over_o, 0);
        check_val("s6_winner", winner_o, 0);
        check_val("s6_state", state_o, 0);
        tick(3);
        rst_ni = 1'b1;
        tick(2);

        // Saturated score
        load_scores(8'd255, 8'd0);
        p1_btn = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (state_o != 3'd0) cnt++;
        end
        check_val("s7_stays_idle", cnt, 0);
        check_val("s7_score_unchanged", p1_score, 255);
        p1_btn = 1'b0;
        tick(10);
        check_val("end_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
